brisc_sequencer: RTL and testbench
==================================

Name: brisc_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the BRISC core.
- Fetches 3-byte instructions over an 8-bit byte memory interface and holds the program counter.
- Drives the operand-B select (imm_ctl), immediate byte, ALU op, register addresses and register write enable.
- Sits between instruction memory and the datapath (register file, operand-B mux, ALU).

Parameters:
RESET_PC, 8'h00, PC value loaded on reset
REG_ADDR_W, 4, register file address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
mem_req  output  1  fetch request, held until mem_ready
mem_addr  output  8  byte address of current fetch beat
mem_rdata  input  8  fetched byte, valid when mem_ready=1
mem_ready  input  1  fetch beat complete this cycle
pc  output  8  address of current instruction
imm_ctl  output  2  operand-B select: 0=reg, 1=immediate, 2=PC+3
immediate  output  8  instruction byte 2
alu_op  output  4  ALU operation code
rd_addr  output  REG_ADDR_W  destination register
rs_addr  output  REG_ADDR_W  source register
reg_we  output  1  register write enable
alu_zero  input  1  ALU result-is-zero flag
instr_done  output  1  one-cycle pulse at instruction retire
illegal_op  output  1  one-cycle pulse on undefined class
halted  output  1  core halted

Behaviour:
- Instruction format: byte0 = {class[3:0], aop[3:0]}; byte1 = {rd[3:0], rs[3:0]}; byte2 = imm8.
- States: FETCH0, FETCH1, FETCH2, EXEC, WB, HALT.
- Reset: on any clk edge with rst=1, from any state including mid-fetch:
  - state=FETCH0, pc=RESET_PC.
  - instruction registers cleared to 0.
  - reg_we, instr_done, illegal_op, halted = 0.
- All outputs are functions of registered state only; no combinational path from inputs.
- FETCHn (n=0..2):
  - mem_req=1, mem_addr=(pc+n) mod 256.
  - On mem_ready=1: latch mem_rdata into byte n and advance. Otherwise stay, with mem_addr stable.
  - First cycle after reset: mem_req=1, mem_addr=RESET_PC.
- mem_ready is ignored outside FETCH states; mem_req=0 in EXEC, WB and HALT.
- Minimum latency: 5 cycles per instruction with zero-wait memory (3 fetch + EXEC + WB).
- Class decode in EXEC; imm_ctl, alu_op and addresses stay stable through EXEC and WB:
  - 0 ALU reg-reg: imm_ctl=0, alu_op=aop, reg_we=1 in WB.
  - 1 ALU reg-imm: imm_ctl=1, alu_op=aop, reg_we=1 in WB.
  - 2 JAL: imm_ctl=2, alu_op=4'hF (pass B), reg_we=1 in WB; next pc=imm8.
  - 3 BEQZ: imm_ctl=0, alu_op=4'hE (pass A, tests rs). alu_zero is sampled at the end of EXEC. Next pc=imm8 if the sample is 1, else pc+3.
  - 4 HALT: EXEC goes to HALT; no WB, no instr_done.
  - 5..15: illegal_op pulses in EXEC; executes as NOP (reg_we=0, next pc=pc+3).
- WB:
  - reg_we asserted for exactly this cycle (classes 0-2 only); instr_done=1.
  - pc updated at the end of WB; return to FETCH0.
- PC arithmetic is 8-bit, modulo 256:
  - pc+3 wraps, e.g. FE -> 01.
  - Fetch addresses wrap, e.g. pc=FF fetches FF, 00, 01.
- HALT: halted=1, all enables 0, pc frozen. Leaves only via rst.
- In FETCH, imm_ctl=0, alu_op=0, reg_we=0.

Test Plan:
- Reset, zero-wait memory, program {0x13,0x21,0x55} at 0x00 -> mem_addr 00,01,02 on consecutive cycles; EXEC imm_ctl=1, alu_op=3, rd=2, rs=1, immediate=0x55; reg_we=1 and instr_done=1 in cycle 5; pc=03.
- JAL {0x20,0x70,0x40} at pc=0x10 -> imm_ctl=2, alu_op=F, rd=7, reg_we=1 in WB; next FETCH0 mem_addr=0x40.
- BEQZ {0x30,0x03,0x80} at pc=0x20: alu_zero=1 -> next pc=0x80; repeat with alu_zero=0 -> next pc=0x23, reg_we never asserted.
- mem_ready low 3 cycles on FETCH1, pc=0xFE -> mem_addr held at FF, mem_req=1 throughout; beat 2 fetched at 0x00; after a reg-reg op, pc=0x01.
- Opcode 0x90 -> illegal_op one-cycle pulse in EXEC, reg_we=0, pc+=3. Then opcode 0x40 -> halted=1, mem_req stays 0 for 20 cycles.
- rst=1 during FETCH2 and during HALT -> next cycle state FETCH0, mem_addr=RESET_PC, halted=0, no reg_we or instr_done pulse.

Source files
------------

// File: rtl/brisc_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the BRISC core.
// Fetches 3-byte instructions over a byte-wide memory port, holds the PC and steers the datapath.
module brisc_sequencer #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter int         REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [7:0]            mem_addr,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ready,
  output logic [7:0]            pc,
  output logic [1:0]            imm_ctl,
  output logic [7:0]            immediate,
  output logic [3:0]            alu_op,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [REG_ADDR_W-1:0] rs_addr,
  output logic                  reg_we,
  input  logic                  alu_zero,
  output logic                  instr_done,
  output logic                  illegal_op,
  output logic                  halted,
  output logic [2:0]            dbg_state
);

  // Memory handshake: a fetch beat completes on any cycle where mem_req=1 and
  // mem_ready=1; mem_req and mem_addr stay stable until then, and mem_ready is
  // ignored whenever mem_req=0.

  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] CLS_RR   = 4'd0;
  localparam logic [3:0] CLS_RI   = 4'd1;
  localparam logic [3:0] CLS_JAL  = 4'd2;
  localparam logic [3:0] CLS_BEQZ = 4'd3;
  localparam logic [3:0] CLS_HALT = 4'd4;

  state_t     state, state_next;
  logic [7:0] pc_q, pc_next;
  logic [7:0] ir0, ir1, ir2;
  logic       zero_q;
  logic [3:0] cls;
  logic [3:0] aop;

  assign cls = ir0[7:4];
  assign aop = ir0[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH0;
      pc_q   <= RESET_PC;
      ir0    <= 8'h00;
      ir1    <= 8'h00;
      ir2    <= 8'h00;
      zero_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        FETCH0: if (mem_ready) ir0 <= mem_rdata;
        FETCH1: if (mem_ready) ir1 <= mem_rdata;
        FETCH2: if (mem_ready) ir2 <= mem_rdata;
        EXEC:   zero_q <= alu_zero;
        WB:     pc_q <= pc_next;
        default: ;
      endcase
    end
  end

  // Branch condition uses the alu_zero value captured at the end of EXEC.
  always_comb begin
    pc_next = pc_q + 8'd3;
    if (cls == CLS_JAL) begin
      pc_next = ir2;
    end else if (cls == CLS_BEQZ && zero_q) begin
      pc_next = ir2;
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_addr   = pc_q;
    imm_ctl    = 2'd0;
    alu_op     = 4'd0;
    reg_we     = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    halted     = 1'b0;
    case (state)
      FETCH0: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) state_next = FETCH1;
      end
      FETCH1: begin
        mem_req  = 1'b1;
        mem_addr = pc_q + 8'd1;
        if (mem_ready) state_next = FETCH2;
      end
      FETCH2: begin
        mem_req  = 1'b1;
        mem_addr = pc_q + 8'd2;
        if (mem_ready) state_next = EXEC;
      end
      EXEC: begin
        if (cls == CLS_HALT) begin
          state_next = HALT;
        end else begin
          state_next = WB;
        end
        illegal_op = (cls > CLS_HALT);
      end
      WB: begin
        state_next = FETCH0;
        instr_done = 1'b1;
        reg_we     = (cls == CLS_RR) || (cls == CLS_RI) || (cls == CLS_JAL);
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_next = FETCH0;
    endcase

    // Datapath steering is held steady across EXEC and WB.
    if (state == EXEC || state == WB) begin
      case (cls)
        CLS_RR:   begin imm_ctl = 2'd0; alu_op = aop;   end
        CLS_RI:   begin imm_ctl = 2'd1; alu_op = aop;   end
        CLS_JAL:  begin imm_ctl = 2'd2; alu_op = 4'hF;  end
        CLS_BEQZ: begin imm_ctl = 2'd0; alu_op = 4'hE;  end
        default:  begin imm_ctl = 2'd0; alu_op = 4'd0;  end
      endcase
    end
  end

  assign pc        = pc_q;
  assign immediate = ir2;
  assign rd_addr   = REG_ADDR_W'(ir1[7:4]);
  assign rs_addr   = REG_ADDR_W'(ir1[3:0]);
  assign dbg_state = state;

endmodule

// File: tb/tb_brisc_sequencer.sv
// Directed bench for brisc_sequencer: byte memory model, retire scoreboard and
// immediate-assertion checks on fetch, decode, branch, wait-state, halt and reset behaviour.
module tb_brisc_sequencer;

  localparam int W = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic [7:0] pc;
  logic [1:0] imm_ctl;
  logic [7:0] immediate;
  logic [3:0] alu_op;
  logic [3:0] rd_addr;
  logic [3:0] rs_addr;
  logic       reg_we;
  logic       alu_zero;
  logic       instr_done;
  logic       illegal_op;
  logic       halted;
  logic [2:0] dbg_state;

  logic [7:0]   mem [256];
  logic [W-1:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  // clock / reset
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  brisc_sequencer #(.RESET_PC(8'h00), .REG_ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .imm_ctl(imm_ctl), .immediate(immediate), .alu_op(alu_op),
    .rd_addr(rd_addr), .rs_addr(rs_addr), .reg_we(reg_we), .alu_zero(alu_zero),
    .instr_done(instr_done), .illegal_op(illegal_op), .halted(halted), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rec(input logic we, input logic [1:0] ic,
                                       input logic [3:0] op, input logic [3:0] rd);
    return {we, ic, op, rd};
  endfunction

  task automatic load3(input logic [7:0] a, input logic [7:0] b0,
                       input logic [7:0] b1, input logic [7:0] b2);
    mem[a]        = b0;
    mem[a + 8'd1] = b1;
    mem[a + 8'd2] = b2;
  endtask

  // Waits (bounded) for the retire pulse, then checks the new PC in FETCH0.
  task automatic retire(input string tag, input logic [7:0] exp_pc, input int exp_ill);
    int ill = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (illegal_op === 1'b1) ill++;
      if (instr_done === 1'b1) break;
      @(negedge clk);
    end
    chk({tag, "_done"}, instr_done, 1);
    chk({tag, "_illegal_pulses"}, ill, exp_ill);
    @(negedge clk);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_fetch_addr"}, mem_addr, exp_pc);
  endtask

  // scoreboard: every retire pops one expected {reg_we, imm_ctl, alu_op, rd}
  always @(negedge clk) begin
    if (!rst && instr_done === 1'b1) begin
      if (exp_q.size() > 0) begin
        chk("sb_retire", {reg_we, imm_ctl, alu_op, rd_addr}, exp_q.pop_front());
      end else begin
        chk("sb_unexpected_retire", instr_done, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cnt;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    load3(8'h00, 8'h13, 8'h21, 8'h55);
    load3(8'h03, 8'h20, 8'h00, 8'h10);
    load3(8'h10, 8'h20, 8'h70, 8'h40);
    load3(8'h40, 8'h20, 8'h00, 8'h20);
    load3(8'h20, 8'h30, 8'h03, 8'h80);
    load3(8'h80, 8'h20, 8'h00, 8'h20);
    load3(8'h23, 8'h20, 8'h00, 8'hFE);
    mem[8'hFE] = 8'h0A;
    mem[8'hFF] = 8'h45;
    mem_ready  = 1'b1;
    alu_zero   = $urandom_range(0, 1) == 1;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", dbg_state, 0);
    chk("rst_mem_req", mem_req, 1);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_pc", pc, 8'h00);
    chk("rst_halted", halted, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_instr_done", instr_done, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_immediate", immediate, 8'h00);
    rst = 1'b0;

    // reg-imm op at 0x00, zero-wait memory
    exp_q.push_back(rec(1'b1, 2'd1, 4'd3, 4'd2));
    @(negedge clk);
    chk("t1_addr1", mem_addr, 8'h01);
    chk("t1_req1", mem_req, 1);
    @(negedge clk);
    chk("t1_addr2", mem_addr, 8'h02);
    @(negedge clk);
    chk("t1_exec_imm_ctl", imm_ctl, 2'd1);
    chk("t1_exec_alu_op", alu_op, 4'd3);
    chk("t1_exec_rd", rd_addr, 4'd2);
    chk("t1_exec_rs", rs_addr, 4'd1);
    chk("t1_exec_immediate", immediate, 8'h55);
    chk("t1_exec_mem_req", mem_req, 0);
    chk("t1_exec_reg_we", reg_we, 0);
    @(negedge clk);
    chk("t1_wb_reg_we", reg_we, 1);
    chk("t1_wb_instr_done", instr_done, 1);
    chk("t1_wb_imm_ctl", imm_ctl, 2'd1);
    @(negedge clk);
    chk("t1_pc", pc, 8'h03);
    chk("t1_next_addr", mem_addr, 8'h03);

    // jumps to reach the directed test points
    exp_q.push_back(rec(1'b1, 2'd2, 4'hF, 4'd0));
    retire("jal_to10", 8'h10, 0);
    exp_q.push_back(rec(1'b1, 2'd2, 4'hF, 4'd7));
    retire("jal_rd7", 8'h40, 0);
    exp_q.push_back(rec(1'b1, 2'd2, 4'hF, 4'd0));
    retire("jal_to20", 8'h20, 0);

    // BEQZ taken, then not taken
    alu_zero = 1'b1;
    exp_q.push_back(rec(1'b0, 2'd0, 4'hE, 4'd0));
    retire("beqz_taken", 8'h80, 0);
    chk("beqz_rs", rs_addr, 4'd3);
    alu_zero = 1'b0;
    exp_q.push_back(rec(1'b1, 2'd2, 4'hF, 4'd0));
    retire("jal_back20", 8'h20, 0);
    exp_q.push_back(rec(1'b0, 2'd0, 4'hE, 4'd0));
    retire("beqz_not_taken", 8'h23, 0);
    exp_q.push_back(rec(1'b1, 2'd2, 4'hF, 4'd0));
    retire("jal_toFE", 8'hFE, 0);

    // wait states on FETCH1 with address wrap
    exp_q.push_back(rec(1'b1, 2'd0, 4'hA, 4'd4));
    @(negedge clk);
    chk("ws_addr_first", mem_addr, 8'hFF);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ws_addr_held", mem_addr, 8'hFF);
      chk("ws_req_held", mem_req, 1);
      chk("ws_state", dbg_state, 1);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("ws_beat2_addr", mem_addr, 8'h00);
    load3(8'h20, 8'h90, 8'h00, 8'h00);
    load3(8'h23, 8'h40, 8'h00, 8'h00);
    retire("wrap_rr", 8'h01, 0);
    chk("wrap_immediate", immediate, 8'h13);

    // 0x01: 21 55 20 decodes as JAL rd=5 -> 0x20
    exp_q.push_back(rec(1'b1, 2'd2, 4'hF, 4'd5));
    retire("jal_rd5", 8'h20, 0);

    // illegal class executes as NOP
    exp_q.push_back(rec(1'b0, 2'd0, 4'd0, 4'd0));
    retire("illegal", 8'h23, 1);

    // HALT
    for (int i = 0; i < 20; i++) begin
      if (halted === 1'b1) break;
      @(negedge clk);
    end
    chk("halt_halted", halted, 1);
    req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = $urandom_range(0, 1) == 1;
      @(negedge clk);
      if (mem_req !== 1'b0 || reg_we !== 1'b0 || halted !== 1'b1) req_cnt++;
    end
    mem_ready = 1'b1;
    chk("halt_quiet_cycles", req_cnt, 0);
    chk("halt_pc_frozen", pc, 8'h23);
    chk("halt_state", dbg_state, 5);

    // reset out of HALT
    rst = 1'b1;
    @(negedge clk);
    chk("rst_halt_state", dbg_state, 0);
    chk("rst_halt_halted", halted, 0);
    chk("rst_halt_addr", mem_addr, 8'h00);
    chk("rst_halt_req", mem_req, 1);
    chk("rst_halt_reg_we", reg_we, 0);
    chk("rst_halt_done", instr_done, 0);
    rst = 1'b0;

    // reset during FETCH2
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_f2_state", dbg_state, 2);
    chk("pre_rst_f2_addr", mem_addr, 8'h02);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_f2_state", dbg_state, 0);
    chk("rst_f2_addr", mem_addr, 8'h00);
    chk("rst_f2_done", instr_done, 0);
    chk("rst_f2_reg_we", reg_we, 0);
    chk("rst_f2_immediate", immediate, 8'h00);
    rst = 1'b0;

    exp_q.push_back(rec(1'b1, 2'd1, 4'd3, 4'd2));
    retire("post_reset", 8'h03, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
